pix_err_acc: RTL and testbench
==============================

# pix_err_acc

Streaming per-channel squared-error accumulator for RGB frames. It takes a reference pixel stream and a DUT pixel stream in lockstep and sums the squared differences separately for R, G and B over a frame of cfg_width × cfg_height pixels. At frame end it presents the three raw loss sums, which feed the comp_matrixes loss/equality calculation: normalisation by 255² × resolution and eq = 1 − loss. It sits directly upstream of that calculation and lets frame comparison run in hardware instead of over matrix objects.

## Interface
- DW, 8: bits per colour channel.
- ACC_W, 48: accumulator width per channel. Must be ≥ 2·DW + 32.
- clk  in  1  clock; all logic rises on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle frame start; sampled only in IDLE or DONE.
- cfg_width  in  16  frame width in pixels; latched on accepted start.
- cfg_height  in  16  frame height in pixels; latched on accepted start.
- a_pix  in  3·DW  reference pixel, {R,G,B}, with R in the MSBs.
- b_pix  in  3·DW  DUT pixel, same packing.
- pix_vld  in  1  a_pix/b_pix valid.
- pix_rdy  out  1  block accepts a pixel pair; transfer occurs when pix_vld && pix_rdy.
- busy  out  1  high in RUN and DRAIN.
- res_r, res_g, res_b  out  ACC_W  Σ(a−b)² per channel.
- res_vld  out  1  results valid; held until the next accepted start or rst.
- err  out  1  zero-size frame requested; valid with res_vld.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- Reset state: IDLE. All outputs are 0.
- IDLE/DONE + start:
  - Latch the sizes and compute total = cfg_width·cfg_height (32-bit).
  - Clear the accumulators, res_vld and err.
  - If total = 0: set err and go to DONE next cycle with all sums 0.
  - Otherwise go to RUN.
- RUN:
  - pix_rdy = 1.
  - Each transfer increments pix_cnt.
  - The transfer with pix_cnt = total−1 moves the FSM to DRAIN.
  - pix_vld gaps are allowed and stall nothing downstream.
- DRAIN: pix_rdy = 0. Wait until the pipeline holds no valid entries, then go to DONE.
- DONE: res_vld = 1; res_* are stable. start behaves as in IDLE.
- start in RUN or DRAIN is ignored.
- Arithmetic, per channel, 3-stage pipeline with a valid bit:
  - S1: d = a − b as a signed DW+1 value, registered.
  - S2: sq = d·d as an unsigned 2·DW value, registered. The maximum is 255² = 65025.
  - S3: acc += zero-extended sq.
  - No saturation is needed: 2³² pixels × 65025 < 2⁴⁸.
- Channels are independent. Identical logic is instantiated three times.

## Timing
- pix_rdy is high in RUN, including the cycle of the last transfer. It is low the cycle after.
- Pixel accepted at cycle n: its square enters acc at the edge ending cycle n+2.
- res_vld rises at cycle L+3, where L is the cycle of the last transfer. No earlier.
- Zero-size frame: start at cycle s gives res_vld = 1 and err = 1 at cycle s+1.
- Throughput: one pixel pair per cycle.
- rst mid-frame:
  - Immediate return to IDLE.
  - Pipeline valids, counters and accumulators clear.
  - No res_vld.
- start in the same cycle res_vld is high (DONE): res_vld drops the next cycle and the new frame begins.

## Configuration
- PIX_ERR_MAXDIFF_EN:
  - Defined: adds outputs max_r, max_g, max_b (DW bits each). Each holds max|a−b| over the frame, tracked from S1, cleared on start, valid with res_vld.
  - Undefined: these ports and registers do not exist. Behaviour is otherwise identical.

## Structure
- Package pix_err_pkg holds:
  - the state enum pix_err_st_t;
  - typedef rgb_pix_t (packed struct r, g, b, each DW bits);
  - localparam default ACC_W;
  - a channel-unpack helper function.
- Sub-module pix_sq_diff: one channel's S1/S2 diff-and-square pipeline with valid. It is instantiated three times. Accumulators and FSM live in pix_err_acc.

## Test plan
- Basic 2×2 frame: a = 0x000000, b = 0xFFFFFF → res_r = res_g = res_b = 260100, err = 0, res_vld exactly 3 cycles after the 4th transfer.
- Identical random 8×8 frames, streamed with random pix_vld gaps → all sums 0, pix_rdy low after the 64th transfer.
- Mixed 1×3 frame:
  - a = {0x0A1400, 0x000000, 0xFF0001}, b = {0x001400, 0x050A00, 0x000000}.
  - Expected: res_r = 100 + 25 + 65025 = 65150, res_g = 0 + 100 + 0 = 100, res_b = 0 + 0 + 1 = 1.
- Zero-size frame: cfg_width = 0, cfg_height = 5, start → err = 1 and res_vld = 1 one cycle later, sums 0. A start while busy is ignored and the counts are unchanged.
- Reset mid-frame: rst after 2 of 4 pixels → outputs 0 and state IDLE. A new 2×2 all-zero-error frame then gives 0 sums.
- With PIX_ERR_MAXDIFF_EN defined, the mixed 1×3 frame → max_r = 255, max_g = 10, max_b = 1.

Source files
------------

// File: rtl/pix_err_pkg.sv
// rtl/pix_err_pkg.sv - shared types, defaults and channel helper for the pix_err_acc block
package pix_err_pkg;

    localparam int PIX_DW    = 8;
    localparam int PIX_ACC_W = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pix_err_st_t;

    typedef struct packed {
        logic [PIX_DW-1:0] r;
        logic [PIX_DW-1:0] g;
        logic [PIX_DW-1:0] b;
    } rgb_pix_t;

    // Channel index 0 = R, 1 = G, 2 = B.
    function automatic logic [PIX_DW-1:0] pix_chan(input rgb_pix_t p, input logic [1:0] c);
        case (c)
            2'd0:    return p.r;
            2'd1:    return p.g;
            default: return p.b;
        endcase
    endfunction

endpackage

// File: rtl/pix_sq_diff.sv
// rtl/pix_sq_diff.sv - one colour channel: S1 signed difference, S2 square, each with a valid bit
// absd_o (|a-b| of the S1 entry) exists only when PIX_ERR_MAXDIFF_EN is defined.
module pix_sq_diff #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vld_i,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    output logic            s1_vld_o,
    output logic            sq_vld_o,
    output logic [2*DW-1:0] sq_o
`ifdef PIX_ERR_MAXDIFF_EN
    ,
    output logic [DW-1:0]   absd_o
`endif
);

    logic signed [DW:0] d_q, d_d;
    logic               s1_vld_q;
    logic [DW-1:0]      mag;
    logic [2*DW-1:0]    sq_q, sq_d;
    logic               sq_vld_q;

    assign d_d = $signed({1'b0, a_i}) - $signed({1'b0, b_i});

    // |d| always fits in DW bits because both operands are unsigned DW-bit values.
    assign mag  = d_q[DW] ? DW'(~d_q[DW-1:0] + DW'(1)) : d_q[DW-1:0];
    assign sq_d = {{DW{1'b0}}, mag} * {{DW{1'b0}}, mag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q      <= '0;
            s1_vld_q <= 1'b0;
            sq_q     <= '0;
            sq_vld_q <= 1'b0;
        end else begin
            d_q      <= d_d;
            s1_vld_q <= vld_i;
            sq_q     <= sq_d;
            sq_vld_q <= s1_vld_q;
        end
    end

    assign s1_vld_o = s1_vld_q;
    assign sq_vld_o = sq_vld_q;
    assign sq_o     = sq_q;
`ifdef PIX_ERR_MAXDIFF_EN
    assign absd_o   = mag;
`endif

endmodule

// File: rtl/pix_err_acc.sv
// rtl/pix_err_acc.sv - per-channel squared-error accumulator over one RGB frame
// Optional max|a-b| outputs are enabled by defining PIX_ERR_MAXDIFF_EN.
module pix_err_acc
    import pix_err_pkg::*;
#(
    parameter int DW    = PIX_DW,
    parameter int ACC_W = PIX_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      cfg_width,
    input  logic [15:0]      cfg_height,
    input  logic [3*DW-1:0]  a_pix,
    input  logic [3*DW-1:0]  b_pix,
    input  logic             pix_vld,
    output logic             pix_rdy,
    output logic             busy,
    output logic [ACC_W-1:0] res_r,
    output logic [ACC_W-1:0] res_g,
    output logic [ACC_W-1:0] res_b,
    output logic             res_vld,
    output logic             err
`ifdef PIX_ERR_MAXDIFF_EN
    ,
    output logic [DW-1:0]    max_r,
    output logic [DW-1:0]    max_g,
    output logic [DW-1:0]    max_b
`endif
);

    pix_err_st_t state_q, state_d;
    logic [31:0] total_q, total_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] frame_total;
    logic        start_ok, xfer, last_xfer;
    logic [2:0]  s1_vld, sq_vld;
    rgb_pix_t    a_rgb, b_rgb;

    assign frame_total = {16'd0, cfg_width} * {16'd0, cfg_height};
    assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign xfer        = pix_vld && (state_q == ST_RUN);
    assign last_xfer   = xfer && (cnt_q == total_q - 32'd1);

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    total_d = frame_total;
                    cnt_d   = '0;
                    err_d   = (frame_total == 32'd0);
                    state_d = (frame_total == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) cnt_d = cnt_q + 32'd1;
                if (last_xfer) state_d = ST_DRAIN;
            end
            // Once S1 is empty the last square is folded in on this edge.
            ST_DRAIN: begin
                if (s1_vld == 3'b000) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            total_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign a_rgb = a_pix;
    assign b_rgb = b_pix;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [DW-1:0]    a_c, b_c;
        logic [2*DW-1:0]  sq;
        logic [ACC_W-1:0] acc_q, acc_d;

        assign a_c = pix_chan(a_rgb, 2'(c));
        assign b_c = pix_chan(b_rgb, 2'(c));

`ifdef PIX_ERR_MAXDIFF_EN
        logic [DW-1:0] absd, max_q, max_d;
`endif

        pix_sq_diff #(.DW(DW)) u_sq (
            .clk      (clk),
            .rst      (rst),
            .vld_i    (xfer),
            .a_i      (a_c),
            .b_i      (b_c),
            .s1_vld_o (s1_vld[c]),
            .sq_vld_o (sq_vld[c]),
            .sq_o     (sq)
`ifdef PIX_ERR_MAXDIFF_EN
            ,
            .absd_o   (absd)
`endif
        );

        always_comb begin
            acc_d = acc_q;
            if (start_ok) acc_d = '0;
            else if (sq_vld[c]) acc_d = acc_q + ACC_W'(sq);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) acc_q <= '0;
            else     acc_q <= acc_d;
        end

`ifdef PIX_ERR_MAXDIFF_EN
        always_comb begin
            max_d = max_q;
            if (start_ok) max_d = '0;
            else if (s1_vld[c] && (absd > max_q)) max_d = absd;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) max_q <= '0;
            else     max_q <= max_d;
        end
`endif
    end

    assign pix_rdy = (state_q == ST_RUN);
    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign res_vld = (state_q == ST_DONE);
    assign err     = err_q;
    assign res_r   = g_ch[0].acc_q;
    assign res_g   = g_ch[1].acc_q;
    assign res_b   = g_ch[2].acc_q;
`ifdef PIX_ERR_MAXDIFF_EN
    assign max_r   = g_ch[0].max_q;
    assign max_g   = g_ch[1].max_q;
    assign max_b   = g_ch[2].max_q;
`endif

endmodule

// File: tb/tb_pix_err_acc.sv
// tb/tb_pix_err_acc.sv - scoreboard bench for pix_err_acc against an arithmetic frame model
module tb_pix_err_acc;

    localparam int DW = 8;
    localparam int AW = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   cfg_width, cfg_height;
    logic [23:0]   a_pix, b_pix;
    logic          pix_vld;
    logic          pix_rdy, busy, res_vld, err;
    logic [AW-1:0] res_r, res_g, res_b;
`ifdef PIX_ERR_MAXDIFF_EN
    logic [DW-1:0] max_r, max_g, max_b;
`endif

    pix_err_acc dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .a_pix      (a_pix),
        .b_pix      (b_pix),
        .pix_vld    (pix_vld),
        .pix_rdy    (pix_rdy),
        .busy       (busy),
        .res_r      (res_r),
        .res_g      (res_g),
        .res_b      (res_b),
        .res_vld    (res_vld),
        .err        (err)
`ifdef PIX_ERR_MAXDIFF_EN
        ,
        .max_r      (max_r),
        .max_g      (max_g),
        .max_b      (max_b)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        longint s[3];
        int     m[3];
        bit     e;
    } exp_t;

    exp_t        sbq[$];
    logic [23:0] pa[$], pb[$];
    int          total = 0;
    int          bad   = 0;
    logic        prev_vld = 1'b0;

    function automatic void chk(string nm, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endfunction

    function automatic void fail_now(string nm);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", nm);
    endfunction

    // Frame-level reference: sum of squared channel differences and peak |diff|.
    function automatic exp_t model(int n);
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            e.s[c] = 0;
            e.m[c] = 0;
        end
        e.e = (n == 0);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 3; c++) begin
                int x, y, d;
                x = int'((pa[i] >> (16 - 8 * c)) & 24'hFF);
                y = int'((pb[i] >> (16 - 8 * c)) & 24'hFF);
                d = x - y;
                e.s[c] += longint'(d * d);
                if ((d < 0 ? -d : d) > e.m[c]) e.m[c] = (d < 0 ? -d : d);
            end
        end
        return e;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (res_vld && !prev_vld) begin
                if (sbq.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    e = sbq.pop_front();
                    chk("res_r", longint'(res_r), e.s[0]);
                    chk("res_g", longint'(res_g), e.s[1]);
                    chk("res_b", longint'(res_b), e.s[2]);
                    chk("err",   longint'(err),   longint'(e.e));
`ifdef PIX_ERR_MAXDIFF_EN
                    chk("max_r", longint'(max_r), longint'(e.m[0]));
                    chk("max_g", longint'(max_g), longint'(e.m[1]));
                    chk("max_b", longint'(max_b), longint'(e.m[2]));
`endif
                end
            end
            prev_vld = res_vld;
        end
    end

    // Streams pa/pb as a w x h frame. busy_at pulses an illegal start mid-frame;
    // abort_at >= 0 stops after that many transfers with no result expected.
    task automatic run_frame(input int w, input int h, input int gap,
                             input int busy_at, input int abort_at);
        int n, idx, guard;
        bit rdy, busy_done;
        n = w * h;
        idx = 0;
        guard = 0;
        busy_done = 1'b0;
        if (abort_at < 0) sbq.push_back(model(n));
        @(posedge clk); #1;
        start = 1'b1;
        cfg_width = 16'(w);
        cfg_height = 16'(h);
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            chk("zero_res_vld", longint'(res_vld), 1);
            chk("zero_err", longint'(err), 1);
            chk("zero_busy", longint'(busy), 0);
            return;
        end
        while (idx < n && guard < 4000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            if (idx == busy_at && !busy_done) begin
                start = 1'b1;
                cfg_width = 16'd0;
                busy_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            pix_vld = ($urandom_range(99) >= gap);
            a_pix = pa[idx];
            b_pix = pb[idx];
            rdy = pix_rdy;
            @(posedge clk);
            if (pix_vld && rdy) idx++;
            #1;
            guard++;
        end
        pix_vld = 1'b0;
        start = 1'b0;
        if (guard >= 4000) begin
            fail_now("stream_timeout");
            return;
        end
        if (abort_at >= 0) return;
        chk("rdy_after_last", longint'(pix_rdy), 0);
        chk("vld_at_L1", longint'(res_vld), 0);
        @(posedge clk); #1;
        chk("vld_at_L2", longint'(res_vld), 0);
        @(posedge clk); #1;
        chk("vld_at_L3", longint'(res_vld), 1);
        chk("busy_done", longint'(busy), 0);
    endtask

    task automatic fill_rand(input int n, input bit same);
        logic [23:0] v;
        pa = {};
        pb = {};
        for (int i = 0; i < n; i++) begin
            v = 24'($urandom);
            pa.push_back(v);
            pb.push_back(same ? v : 24'($urandom));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b1;
        start = 1'b0;
        cfg_width = '0;
        cfg_height = '0;
        a_pix = '0;
        b_pix = '0;
        pix_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_res_vld", longint'(res_vld), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_rdy", longint'(pix_rdy), 0);
        chk("rst_err", longint'(err), 0);
        chk("rst_res_r", longint'(res_r), 0);

        pa = {};
        pb = {};
        for (int i = 0; i < 4; i++) begin
            pa.push_back(24'h000000);
            pb.push_back(24'hFFFFFF);
        end
        run_frame(2, 2, 0, -1, -1);
        chk("basic_r_const", longint'(res_r), 260100);

        fill_rand(64, 1'b1);
        run_frame(8, 8, 40, -1, -1);

        pa = '{24'h0A1400, 24'h000000, 24'hFF0001};
        pb = '{24'h001400, 24'h050A00, 24'h000000};
        run_frame(1, 3, 0, -1, -1);

        fill_rand(12, 1'b0);
        run_frame(3, 4, 20, 5, -1);

        for (int k = 0; k < 4; k++) begin
            int w, h;
            w = int'($urandom_range(6, 1));
            h = int'($urandom_range(6, 1));
            fill_rand(w * h, 1'b0);
            run_frame(w, h, 30, -1, -1);
        end

        fill_rand(4, 1'b0);
        pa[0] = 24'hFFFFFF;
        pb[0] = 24'h000000;
        run_frame(2, 2, 0, -1, 2);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_res_r", longint'(res_r), 0);
        chk("mid_rst_res_g", longint'(res_g), 0);
        chk("mid_rst_res_b", longint'(res_b), 0);
        chk("mid_rst_vld", longint'(res_vld), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_rdy", longint'(pix_rdy), 0);

        pa = {};
        pb = {};
        run_frame(0, 5, 0, -1, -1);

        fill_rand(4, 1'b1);
        run_frame(2, 2, 0, -1, -1);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", longint'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
